// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared types, funct3 encodings and FSM states for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    MW_B = 2'd0,
    MW_H = 2'd1,
    MW_W = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic mem_width_t width_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MW_B;
      2'b01:   return MW_H;
      default: return MW_W;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Data-memory req/ready bus between the LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic       mem_req;
  logic       mem_we;
  addr_t      mem_addr;
  logic [3:0] mem_be;
  data_t      mem_wdata;
  logic       mem_ready;
  data_t      mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_align
// Description : Byte-enable/lane alignment, load extension and legality check.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  wire logic [2:0] funct3,
  input  wire logic       is_write,
  input  wire logic [1:0] addr_lo,
  input  wire data_t      store_data,
  input  wire data_t      rdata,
  output logic [3:0]      be,
  output data_t           wdata,
  output data_t           load_ext,
  output logic            legal
);

  mem_width_t width;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        f3_ok;
  logic        aligned;

  assign width = width_of(funct3);

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (width)
      MW_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MW_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    rbyte = rdata[7:0];
    case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_ext = rdata;
    case (funct3)
      F3_LB:   load_ext = {{24{rbyte[7]}}, rbyte};
      F3_LH:   load_ext = {{16{rhalf[15]}}, rhalf};
      F3_LBU:  load_ext = {24'd0, rbyte};
      F3_LHU:  load_ext = {16'd0, rhalf};
      default: load_ext = rdata;
    endcase
  end

  always_comb begin
    if (is_write) begin
      f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
    end else begin
      f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    end
    case (width)
      MW_B:    aligned = 1'b1;
      MW_H:    aligned = ~addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase
    legal = f3_ok & aligned;
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multicycle load/store stage driving a req/ready memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         cfsm__mem_start,
  input  wire logic         cfsm__mem_write,
  input  wire logic [2:0]   funct3,
  input  wire addr_t        addr,
  input  wire data_t        store_data,
  load_store_unit_if.master mem,
  output data_t             load_data,
  output logic              done,
  output logic              fault,
  output logic              busy
);

  lsu_state_t  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  addr_t       addr_q, addr_d;
  data_t       sdata_q, sdata_d;
  data_t       load_data_q, load_data_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  logic        al_sel_raw;
  logic [2:0]  al_funct3;
  logic        al_write;
  logic [1:0]  al_addr_lo;
  data_t       al_sdata;
  logic [3:0]  al_be;
  data_t       al_wdata;
  data_t       al_load_ext;
  logic        al_legal;

  // In IDLE the aligner judges the live inputs; afterwards it works on the latched copy.
  assign al_sel_raw = (state_q == S_IDLE);
  assign al_funct3  = al_sel_raw ? funct3          : funct3_q;
  assign al_write   = al_sel_raw ? cfsm__mem_write : write_q;
  assign al_addr_lo = al_sel_raw ? addr[1:0]       : addr_q[1:0];
  assign al_sdata   = al_sel_raw ? store_data      : sdata_q;

  load_store_unit_align u_align (
    .funct3     (al_funct3),
    .is_write   (al_write),
    .addr_lo    (al_addr_lo),
    .store_data (al_sdata),
    .rdata      (mem.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_ext   (al_load_ext),
    .legal      (al_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      sdata_q     <= '0;
      load_data_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      load_data_q <= load_data_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfsm__mem_start) begin
          write_d  = cfsm__mem_write;
          funct3_d = funct3;
          addr_d   = addr;
          sdata_d  = store_data;
          state_d  = al_legal ? S_REQ : S_FAULT;
        end
      end
      S_REQ: begin
        if (mem.mem_ready) begin
          state_d   = S_DONE;
          tmo_cnt_d = '0;
          if (!write_q) begin
            load_data_d = al_load_ext;
          end
        end else if ((TIMEOUT_CYCLES != 0) && ((tmo_cnt_q + 32'd1) == TIMEOUT_CYCLES)) begin
          state_d   = S_FAULT;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = '0;
    done          = 1'b0;
    fault         = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = write_q;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
        mem.mem_be    = al_be;
        mem.mem_wdata = al_wdata;
      end
      S_DONE:  done  = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign load_data = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Randomized self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        fault;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ld   = 32'd0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfsm__mem_start (start),
    .cfsm__mem_write (write),
    .funct3          (funct3),
    .addr            (addr),
    .store_data      (store_data),
    .mem             (bus),
    .load_data       (load_data),
    .done            (done),
    .fault           (fault),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access size in bytes, lane offset, and byte-wise lane arithmetic.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output logic legal, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size;
    int off;
    logic [31:0] mask;
    off  = int'(a % 4);
    size = 1 << f3[1:0];
    if (w) legal = (f3 <= 3'd2);
    else   legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (size <= 4 && (off % size) != 0) legal = 1'b0;
    be = 4'b0000;
    wd = 32'd0;
    ld = rd >> (8 * off);
    if (size <= 4) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) be[i] = 1'b1;
        wd[8*i +: 8] = sd[8*(i % size) +: 8];
      end
    end
    if (size < 4) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      ld   = ld & mask;
      if (!f3[2] && ld[8*size-1]) ld = ld | ~mask;
    end
  endfunction

  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int delay, input bit poke);
    logic legal;
    logic [3:0] be;
    logic [31:0] wd;
    logic [31:0] ld;
    int ncyc;
    model(w, f3, a, sd, rd, legal, be, wd, ld);
    @(negedge clk);
    start = 1'b1; write = w; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    start = 1'b0;
    write = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    if (!legal) begin
      check_val("flt_pulse", fault, 1);
      check_val("flt_noreq", bus.mem_req, 0);
      check_val("flt_ld", load_data, exp_ld);
      @(posedge clk); #1;
      check_val("flt_end", fault, 0);
      check_val("flt_busy", busy, 0);
      check_val("flt_noreq2", bus.mem_req, 0);
    end else begin
      ncyc = (delay >= TMO) ? TMO : delay + 1;
      for (int k = 0; k < ncyc; k++) begin
        check_val("req", bus.mem_req, 1);
        check_val("we", bus.mem_we, w);
        check_val("maddr", bus.mem_addr, {a[31:2], 2'b00});
        check_val("be", bus.mem_be, be);
        if (w) check_val("wdata", bus.mem_wdata, wd);
        check_val("no_done", done, 0);
        check_val("no_fault", fault, 0);
        check_val("busy", busy, 1);
        bus.mem_ready = (k == delay);
        bus.mem_rdata = (k == delay) ? rd : $urandom;
        if (poke && k == 0) begin
          start = 1'b1; write = 1'b0; funct3 = 3'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        bus.mem_ready = 1'b0;
      end
      if (delay >= TMO) begin
        check_val("tmo_fault", fault, 1);
        check_val("tmo_noreq", bus.mem_req, 0);
        check_val("tmo_nodone", done, 0);
        check_val("tmo_ld", load_data, exp_ld);
      end else begin
        if (!w) exp_ld = ld;
        check_val("done", done, 1);
        check_val("done_noreq", bus.mem_req, 0);
        check_val("done_nofault", fault, 0);
        check_val("load_data", load_data, exp_ld);
      end
      @(posedge clk); #1;
      check_val("end_done", done, 0);
      check_val("end_fault", fault, 0);
      check_val("end_busy", busy, 0);
      check_val("end_req", bus.mem_req, 0);
    end
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", bus.mem_req, 0);
    check_val("rst_we", bus.mem_we, 0);
    check_val("rst_addr", bus.mem_addr, 0);
    check_val("rst_be", bus.mem_be, 0);
    check_val("rst_wdata", bus.mem_wdata, 0);
    check_val("rst_ld", load_data, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_busy", busy, 0);
    reset = 1'b0;

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    check_val("lw_val", load_data, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0);
    check_val("lb_val", load_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 0);
    check_val("lbu_val", load_data, 32'h00000080);
    access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3, 1);
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    check_val("flt_keep", load_data, 32'h00000080);
    access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 99, 0);
    access(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0);

    // Reset in the middle of a request.
    @(negedge clk);
    start = 1'b1; write = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    start = 1'b0; bus.mem_ready = 1'b0;
    check_val("mid_req", bus.mem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ld = 32'd0;
    check_val("mid_rst_req", bus.mem_req, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_ld", load_data, 0);
    @(posedge clk); #1;
    check_val("mid_rst_done2", done, 0);
    check_val("mid_rst_fault2", fault, 0);

    for (int t = 0; t < 300; t++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, d,
             ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
